// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared select encoding and defaults for the 1:2 stream demux
package demux_pkg;

    // Same select encoding as the 2:1 datapath mux
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small synchronous FIFO with registered occupancy and zeroed empty head
module stream_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO never takes a push, even if it is popped in the same cycle
    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && head_valid;
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Pointers wrap modulo DEPTH; count tracks net push/pop per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever count is zero
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/demux_1to2_stream.sv
// rtl/demux_1to2_stream.sv - registered 1:2 stream demux steering each beat to A or B by in_sel
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
);

    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;
    logic accept;

    // Ready looks only at the selected side's occupancy, never at the consumers' ready
    assign in_ready = (in_sel == SEL_B) ? !full_b : !full_a;
    assign accept   = in_valid && in_ready;
    assign push_a   = accept && (in_sel == SEL_A);
    assign push_b   = accept && (in_sel == SEL_B);

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_a),
        .push_data  (in_data),
        .full       (full_a),
        .pop        (a_ready),
        .head_valid (a_valid),
        .head_data  (a_data),
        .count      (a_count)
    );

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_b),
        .push_data  (in_data),
        .full       (full_b),
        .pop        (b_ready),
        .head_valid (b_valid),
        .head_data  (b_data),
        .count      (b_count)
    );

endmodule
